// File: rtl/mem_1r1w_masked_pkg.sv
// Shared types and helpers for the lowered memory family: clear-FSM state,
// address-width helper and the legal read-latency window.
package mem_lower_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 4;

  // Address width for n words; a single-word memory still gets one address bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(n)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_1r1w_masked_if.sv
// Read/write port bundle of mem_1r1w_masked. There is no backpressure per
// request: a read or write is accepted on any clk edge where ready && *_en.
interface mem_1r1w_masked_if
  import mem_lower_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8
);
  localparam int AW = clog2_min1(DEPTH);
  localparam int MW = WIDTH / MASK_GRAN;

  logic             ready;
  logic [AW-1:0]    R0_addr;
  logic             R0_en;
  logic [WIDTH-1:0] R0_data;
  logic             R0_valid;
  logic [AW-1:0]    W0_addr;
  logic             W0_en;
  logic [WIDTH-1:0] W0_data;
  logic [MW-1:0]    W0_mask;

  modport master (
    input  ready, R0_data, R0_valid,
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask
  );

  modport slave (
    output ready, R0_data, R0_valid,
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask
  );

endinterface

// File: rtl/mem_1r1w_masked_clear_seq.sv
// After-reset clear sequencer: walks every address once writing zero, then
// parks in READY for good.
module mem_clear_seq
  import mem_lower_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int INIT_ZERO = 1,
  localparam int AW       = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          ready_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output clr_state_e    state_o
);

  localparam clr_state_e    RESET_STATE = (INIT_ZERO != 0) ? CLEAR : READY;
  localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == CLEAR) begin
      if (addr_q == LAST_ADDR) begin
        state_d = READY;
        addr_d  = '0;
      end else begin
        addr_d  = addr_q + AW'(1);
      end
    end
  end

  always_comb begin
    ready_o    = (state_q == READY);
    clr_we_o   = (state_q == CLEAR);
    clr_addr_o = addr_q;
    state_o    = state_q;
  end

endmodule

// File: rtl/mem_1r1w_masked.sv
// Simple-dual-port memory with per-granule write mask, post-reset clear,
// selectable collision semantics and a READ_LATENCY-deep read pipeline.
module mem_1r1w_masked
  import mem_lower_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int WIDTH        = 64,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_1r1w_masked_if.slave    bus,
  output clr_state_e          clr_state_o
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int MW = WIDTH / MASK_GRAN;

  if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
    $error("mem_1r1w_masked: WIDTH must be a multiple of MASK_GRAN");
  end
  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_lat
    $error("mem_1r1w_masked: READ_LATENCY out of range");
  end

  logic          ready;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  mem_clear_seq #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (INIT_ZERO)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .state_o    (clr_state_o)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             w_in_range, r_in_range;
  logic             user_we, rd_fire, collide;
  logic [WIDTH-1:0] w_old, w_merged, rd_now;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  always_comb begin
    w_in_range = (32'(bus.W0_addr) < DEPTH);
    r_in_range = (32'(bus.R0_addr) < DEPTH);
    user_we    = ready && bus.W0_en && w_in_range;
    rd_fire    = ready && bus.R0_en;
    collide    = user_we && (bus.W0_addr == bus.R0_addr);
    w_old      = w_in_range ? mem_q[bus.W0_addr] : '0;
    w_merged   = w_old;
    for (int g = 0; g < MW; g++) begin
      if (bus.W0_mask[g]) w_merged[g*MASK_GRAN +: MASK_GRAN] = bus.W0_data[g*MASK_GRAN +: MASK_GRAN];
    end
    // Out-of-range reads still complete, returning zero.
    if (!r_in_range)                      rd_now = '0;
    else if (collide && WRITE_FIRST != 0) rd_now = w_merged;
    else                                  rd_now = mem_q[bus.R0_addr];
  end

  // The clear sequencer only writes while ready is low, so it never races W0.
  always_comb begin
    wr_en   = clr_we || user_we;
    wr_addr = clr_we ? clr_addr : bus.W0_addr;
    wr_data = clr_we ? '0 : w_merged;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  logic [READ_LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]        dat_q [READ_LATENCY];

  // Each stage only advances data behind a valid, so R0_data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_fire;
      if (rd_fire) dat_q[0] <= rd_now;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign bus.ready    = ready;
  assign bus.R0_valid = vld_q[READ_LATENCY-1];
  assign bus.R0_data  = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_1r1w_masked.sv
// Directed bench: three memories (latency 1 write-first, latency 3 read-first,
// depth 20) share one stimulus stream and are checked against per-instance expectations.
module tb_mem_1r1w_masked;
  import mem_lower_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus signals ----------------
  logic        r_en = 1'b0;
  logic [4:0]  r_addr = '0;
  logic        w_en = 1'b0;
  logic [4:0]  w_addr = '0;
  logic [63:0] w_data = '0;
  logic [7:0]  w_mask = '0;

  mem_1r1w_masked_if #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8)) if_a ();
  mem_1r1w_masked_if #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8)) if_b ();
  mem_1r1w_masked_if #(.DEPTH(20), .WIDTH(64), .MASK_GRAN(8)) if_c ();

  assign if_a.R0_en = r_en;  assign if_a.R0_addr = r_addr;
  assign if_a.W0_en = w_en;  assign if_a.W0_addr = w_addr;
  assign if_a.W0_data = w_data; assign if_a.W0_mask = w_mask;
  assign if_b.R0_en = r_en;  assign if_b.R0_addr = r_addr;
  assign if_b.W0_en = w_en;  assign if_b.W0_addr = w_addr;
  assign if_b.W0_data = w_data; assign if_b.W0_mask = w_mask;
  assign if_c.R0_en = r_en;  assign if_c.R0_addr = r_addr;
  assign if_c.W0_en = w_en;  assign if_c.W0_addr = w_addr;
  assign if_c.W0_data = w_data; assign if_c.W0_mask = w_mask;

  clr_state_e st_a, st_b, st_c;

  mem_1r1w_masked #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1),
                    .WRITE_FIRST(1), .INIT_ZERO(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave), .clr_state_o(st_a));
  mem_1r1w_masked #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(3),
                    .WRITE_FIRST(0), .INIT_ZERO(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave), .clr_state_o(st_b));
  mem_1r1w_masked #(.DEPTH(20), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1),
                    .WRITE_FIRST(1), .INIT_ZERO(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave), .clr_state_o(st_c));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[3][$];
  int          iss_q[3][$];
  int          lat[3] = '{1, 3, 1};
  int          depth[3] = '{32, 32, 20};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [63:0] d);
    if (v === 1'b1) begin
      if (exp_q[k].size() == 0) begin
        check($sformatf("dut%0d_spurious_valid", k), 64'd1, 64'd0);
      end else begin
        check($sformatf("dut%0d_rdata", k), d, exp_q[k].pop_front());
        check($sformatf("dut%0d_rlatency", k), 64'(cyc), 64'(iss_q[k].pop_front() + lat[k]));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if_a.R0_valid, if_a.R0_data);
    mon(1, if_b.R0_valid, if_b.R0_data);
    mon(2, if_c.R0_valid, if_c.R0_data);
  end

  function automatic logic rdy(input int k);
    case (k)
      0:       return if_a.ready;
      1:       return if_b.ready;
      default: return if_c.ready;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic re, input logic [4:0] ra, input logic we,
                       input logic [4:0] wa, input logic [63:0] wd, input logic [7:0] wm,
                       input logic push, input logic [63:0] ea, input logic [63:0] eb,
                       input logic [63:0] ec);
    r_en = re; r_addr = ra; w_en = we; w_addr = wa; w_data = wd; w_mask = wm;
    if (re && push) begin
      exp_q[0].push_back(ea); exp_q[1].push_back(eb); exp_q[2].push_back(ec);
      for (int k = 0; k < 3; k++) iss_q[k].push_back(cyc);
    end
    @(posedge clk);
    #1;
    r_en = 1'b0; w_en = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic [7:0] m);
    drive(1'b0, 5'd0, 1'b1, a, d, m, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [63:0] ea, input logic [63:0] eb,
                    input logic [63:0] ec);
    drive(1'b1, a, 1'b0, 5'd0, '0, 8'h00, 1'b1, ea, eb, ec);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (rdy(k) !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("dut%0d_ready_cycles", k), 64'(n), 64'(depth[k]));
  endtask

  task automatic release_and_wait();
    @(negedge clk);
    rst_n = 1'b1;
    fork
      wait_ready(0);
      wait_ready(1);
      wait_ready(2);
      begin
        // Traffic during the clear must be dropped and produce no read result.
        @(posedge clk); #1;
        drive(1'b1, 5'd2, 1'b1, 5'd2, 64'hDEAD_BEEF_0000_0002, 8'hFF, 1'b0, '0, '0, '0);
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_a"}, 64'(if_a.ready), 64'd0);
    check({tag, "_ready_b"}, 64'(if_b.ready), 64'd0);
    check({tag, "_ready_c"}, 64'(if_c.ready), 64'd0);
    check({tag, "_valid_a"}, 64'(if_a.R0_valid), 64'd0);
    check({tag, "_valid_b"}, 64'(if_b.R0_valid), 64'd0);
    check({tag, "_valid_c"}, 64'(if_c.R0_valid), 64'd0);
    check({tag, "_state_a"}, 64'(st_a), 64'(CLEAR));
    check({tag, "_state_b"}, 64'(st_b), 64'(CLEAR));
    check({tag, "_state_c"}, 64'(st_c), 64'(CLEAR));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_data_a", if_a.R0_data, 64'd0);
    check("reset_data_b", if_b.R0_data, 64'd0);
    check("reset_data_c", if_c.R0_data, 64'd0);

    // Clear: every word reads zero (out-of-range words of dut_c also read zero).
    release_and_wait();
    for (int i = 0; i < 32; i++) rd(5'(i), 64'd0, 64'd0, 64'd0);
    idle(6);

    // Masked write: only the low four bytes are replaced.
    wr(5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(5'd5, 64'h1122_3344_5566_7788, 8'h0F);
    rd(5'd5, 64'hFFFF_FFFF_5566_7788, 64'hFFFF_FFFF_5566_7788, 64'hFFFF_FFFF_5566_7788);
    idle(6);

    // Collisions: full-mask then partial-mask same-address read/write.
    wr(5'd3, 64'h0000_0000_0000_00AA, 8'hFF);
    drive(1'b1, 5'd3, 1'b1, 5'd3, 64'h0000_0000_0000_0055, 8'hFF, 1'b1,
          64'h55, 64'hAA, 64'h55);
    rd(5'd3, 64'h55, 64'h55, 64'h55);
    drive(1'b1, 5'd3, 1'b1, 5'd3, 64'h1234_5678_9ABC_DE00, 8'h02, 1'b1,
          64'hDE55, 64'h55, 64'hDE55);
    rd(5'd3, 64'hDE55, 64'hDE55, 64'hDE55);
    idle(6);

    // Streaming: eight back-to-back reads, latency checked per result.
    for (int i = 0; i < 8; i++) wr(5'(i), 64'h100 + 64'(i), 8'hFF);
    for (int i = 0; i < 8; i++) rd(5'(i), 64'h100 + 64'(i), 64'h100 + 64'(i), 64'h100 + 64'(i));
    idle(6);
    check("hold_data_a", if_a.R0_data, 64'h107);
    check("hold_data_b", if_b.R0_data, 64'h107);
    check("hold_valid_b", 64'(if_b.R0_valid), 64'd0);

    // Out-of-range: address 25 exists only in the 32-word memories.
    wr(5'd25, 64'h0000_0000_0000_CAFE, 8'hFF);
    rd(5'd25, 64'hCAFE, 64'hCAFE, 64'h0);
    for (int i = 0; i < 20; i++) begin
      logic [63:0] e;
      e = (i < 8) ? 64'h100 + 64'(i) : 64'd0;
      rd(5'(i), e, e, e);
    end
    idle(6);

    // Reset mid-clear: the sequencer restarts at zero and wipes old contents.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_ready");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_midclear");
    release_and_wait();
    for (int i = 0; i < 32; i++) rd(5'(i), 64'd0, 64'd0, 64'd0);
    idle(6);

    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d_pending_reads", k), 64'(exp_q[k].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_1r1w_masked.md
Name: mem_1r1w_masked

Overview:
- Parametrised single-clock simple-dual-port memory (one read port R0, one write port W0) with a per-granule write mask and configurable read latency.
- Next generation of the 1RW lowered memory, used where a Chisel memory requests separate read/write ports, a mask granularity, or deterministic contents after reset.
- Adds an after-reset clear sequencer, read-valid tracking, and defined same-address read/write collision behaviour.

Parameters:
- DEPTH, 32: number of words; need not be a power of two.
- WIDTH, 64: bits per word.
- MASK_GRAN, 8: bits per write-mask granule; WIDTH must be a multiple of it. MASK_GRAN = WIDTH means unmasked.
- READ_LATENCY, 1: cycles from R0_en to R0_data; legal range 1..4.
- WRITE_FIRST, 1: on a same-cycle, same-address collision, 1 returns the new (merged) data and 0 returns the old data.
- INIT_ZERO, 1: 1 clears every word to 0 after reset; 0 means ready immediately and contents are undefined.

Ports:
- clk  in  1  single clock for both ports.
- rst_n  in  1  asynchronous, active-low reset.
- ready  out  1  high when the ports accept traffic.
- R0_addr  in  AW=max(1,clog2(DEPTH))  read address.
- R0_en  in  1  read request.
- R0_data  out  WIDTH  read data.
- R0_valid  out  1  R0_data holds the result of a read issued READ_LATENCY cycles earlier.
- W0_addr  in  AW  write address.
- W0_en  in  1  write request.
- W0_data  in  WIDTH  write data.
- W0_mask  in  WIDTH/MASK_GRAN  per-granule write enable; bit i covers data bits [i*MASK_GRAN +: MASK_GRAN].

Behaviour:
- Reset values: ready=0, R0_valid=0, R0_data=0, the read pipeline is flushed, and the clear FSM goes to CLEAR with clear address 0. Array contents are not reset directly.
- Clear FSM states:
  - CLEAR: writes 0 to address clr_addr and increments clr_addr each cycle. When clr_addr = DEPTH-1 it moves to READY. CLEAR therefore lasts exactly DEPTH cycles after rst_n rises.
  - READY: terminal state; ready=1.
  - With INIT_ZERO=0 the FSM leaves reset directly in READY.
- While ready=0: R0_en and W0_en are ignored, no R0_valid is produced, and user writes are dropped.
- Reset asserted mid-CLEAR: the FSM restarts from address 0 after release.
- Write: on the clk edge with ready & W0_en, granule i at W0_addr takes W0_data's granule i only when W0_mask[i]=1; other granules keep their value. The write is visible to reads issued on the next cycle and later.
- Read: ready & R0_en at edge t makes R0_valid=1 and R0_data=mem[R0_addr] at edge t+READ_LATENCY.
  - Back-to-back reads give one result per cycle.
  - R0_data holds its last value when R0_valid=0.
- Collision (R0_en & W0_en, equal addresses, same cycle):
  - WRITE_FIRST=1: the read returns the masked-merged new word.
  - WRITE_FIRST=0: the read returns the pre-write word.
- Out-of-range address (>= DEPTH, only possible for non-power-of-two DEPTH):
  - The write is dropped.
  - The read returns 0 with R0_valid=1.
- Parameter legality is checked at elaboration: WIDTH % MASK_GRAN == 0, and READ_LATENCY is within 1..4.

Decomposition:
- Package mem_lower_pkg holds:
  - the clear-FSM state enum (CLEAR, READY);
  - a clog2 helper;
  - the legal READ_LATENCY bounds.
- Sub-module mem_clear_seq (parameter DEPTH) contains the clear FSM and address counter. It outputs ready, clr_we and clr_addr.
- The top level muxes the clear write against the W0 write, and holds the array, the mask merge, the collision bypass and the READ_LATENCY delay line (data plus valid).

Test Plan:
- Clear: DEPTH=32, INIT_ZERO=1, release reset → ready rises exactly 32 cycles later; reading all addresses returns 0 with R0_valid one cycle after each R0_en.
- Masked write: write 0xFFFF_FFFF_FFFF_FFFF to addr 5, then write 0x1122_3344_5566_7788 with mask 0x0F → a read of addr 5 returns 0xFFFF_FFFF_5566_7788.
- Collision: addr 3 holds 0xAA; in the same cycle write 0x55 (full mask) and read addr 3 → returns 0x55 with WRITE_FIRST=1 and 0xAA with WRITE_FIRST=0; a following read returns 0x55 in both cases.
- Latency/streaming: READ_LATENCY=3, reads of addrs 0..7 on consecutive cycles → R0_valid high for 8 consecutive cycles starting 3 cycles after the first R0_en, with data in address order; R0_data holds afterwards.
- Reset mid-clear: assert rst_n=0 at clear cycle 10 → R0_valid=0 and ready=0 immediately; after release ready rises DEPTH cycles later and all words read 0.
- Non-power-of-two: DEPTH=20, write to addr 25 and then read addr 25 → returns 0; addrs 0..19 are unchanged; writes issued while ready=0 are lost.
